fft_spectrum_capture: RTL and testbench

Downstream consumer of the 512-point FFT core's Avalon-ST source port; the FFT's sink side is fed by the FFT start/framing generator. Per frame: squared magnitude of every bin, stored into one half of an internal ping-pong RAM, and peak bin tracked. Frame integrity checked (sop/eop/length/error). Publishes the last good frame to a random-access read port for downstream display/UART logic.

---
 rtl/fft_spectrum_capture_if.sv | 26 ++
 rtl/fft_spectrum_capture.sv | 173 +++++++++++++++++
 tb/tb_fft_spectrum_capture.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_spectrum_capture_if.sv
// rtl/fft_spectrum_capture_if.sv - FFT source-port stream bundle (Avalon-ST style beats)
interface fft_spectrum_capture_if #(
    parameter int DW   = 16,
    parameter int EXPW = 6
);
    logic                   source_valid;
    logic                   source_ready;
    logic                   source_sop;
    logic                   source_eop;
    logic signed [DW-1:0]   source_real;
    logic signed [DW-1:0]   source_imag;
    logic [EXPW-1:0]        source_exp;
    logic [1:0]             source_error;

    modport master (
        output source_valid, source_sop, source_eop, source_real, source_imag,
               source_exp, source_error,
        input  source_ready
    );

    modport slave (
        input  source_valid, source_sop, source_eop, source_real, source_imag,
               source_exp, source_error,
        output source_ready
    );
endinterface

// File: rtl/fft_spectrum_capture.sv
// rtl/fft_spectrum_capture.sv - per-frame |X|^2 capture into ping-pong RAM with peak search
module fft_spectrum_capture #(
    parameter int N_POINTS   = 512,
    parameter int DW         = 16,
    parameter int EXPW       = 6,
    parameter int PEAK_START = 1,
    localparam int AW        = $clog2(N_POINTS)
) (
    input  logic              clk,
    input  logic              rst,
    fft_spectrum_capture_if.slave src,
    input  logic [AW-1:0]     rd_addr,
    output logic [2*DW-1:0]   rd_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [AW-1:0]     peak_bin,
    output logic [2*DW-1:0]   peak_mag,
    output logic [EXPW-1:0]   frame_exp,
    output logic              busy
);
    typedef enum logic {ARMED, CAPTURE} state_t;

    typedef struct packed {
        logic [AW-1:0]   idx;
        logic [EXPW-1:0] bexp;
        logic            first;
        logic            done;
        logic            err;
    } meta_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              taint_q, taint_d;
    logic              ready_q;

    logic              accept, beat_we, beat_first, beat_last, ev_done, ev_err;
    logic [AW-1:0]     beat_idx;

    logic              s0_v_q, s1_v_q, s2_v_q;
    meta_t             s0_meta_q, s1_meta_q, s2_meta_q;
    logic signed [DW-1:0] s0_re_q, s0_im_q, s1_re_q, s1_im_q;
    logic signed [2*DW-1:0] re_x, im_x;
    logic [2*DW-1:0]   sq_re_q, sq_im_q, mag;

    logic [2*DW-1:0]   mem [0:2*N_POINTS-1];
    logic              pub_bank_q;
    logic [AW-1:0]     run_bin_q, base_bin, nxt_bin, peak_bin_q;
    logic [2*DW-1:0]   run_mag_q, base_mag, nxt_mag, peak_mag_q, rd_data_q;
    logic [EXPW-1:0]   run_exp_q, nxt_exp, frame_exp_q;
    logic              frame_done_q, frame_err_q;

    assign accept = src.source_valid && ready_q;

    // Any sop restarts the frame at index 0; in CAPTURE that also flags the abandoned frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        taint_d    = taint_q;
        beat_we    = 1'b0;
        beat_idx   = cnt_q;
        beat_first = 1'b0;
        beat_last  = 1'b0;
        ev_done    = 1'b0;
        ev_err     = 1'b0;
        if (accept) begin
            if (src.source_sop) begin
                beat_we    = 1'b1;
                beat_idx   = '0;
                beat_first = 1'b1;
                taint_d    = |src.source_error;
                ev_err     = (state_q == CAPTURE);
            end else if (state_q == CAPTURE) begin
                beat_we = 1'b1;
                taint_d = taint_q | (|src.source_error);
            end
            if (beat_we) begin
                beat_last = (beat_idx == AW'(N_POINTS - 1));
                if (src.source_eop || beat_last) begin
                    state_d = ARMED;
                    if (src.source_eop && beat_last && !taint_d) ev_done = 1'b1;
                    else                                         ev_err  = 1'b1;
                end else begin
                    state_d = CAPTURE;
                    cnt_d   = beat_idx + AW'(1);
                end
            end
        end
    end

    assign re_x = s1_re_q;
    assign im_x = s1_im_q;
    assign mag  = sq_re_q + sq_im_q;

    // Peak restarts at (PEAK_START, 0) on bin 0 so an all-zero frame reports PEAK_START.
    always_comb begin
        base_bin = s2_meta_q.first ? AW'(PEAK_START) : run_bin_q;
        base_mag = s2_meta_q.first ? '0 : run_mag_q;
        nxt_exp  = s2_meta_q.first ? s2_meta_q.bexp : run_exp_q;
        nxt_bin  = base_bin;
        nxt_mag  = base_mag;
        if (s2_meta_q.idx >= AW'(PEAK_START) && mag > base_mag) begin
            nxt_bin = s2_meta_q.idx;
            nxt_mag = mag;
        end
    end

    always_ff @(posedge clk) begin
        s0_meta_q <= '{idx: beat_idx, bexp: src.source_exp, first: beat_first,
                       done: ev_done, err: ev_err};
        s0_re_q   <= src.source_real;
        s0_im_q   <= src.source_imag;
        s1_meta_q <= s0_meta_q;
        s1_re_q   <= s0_re_q;
        s1_im_q   <= s0_im_q;
        s2_meta_q <= s1_meta_q;
        sq_re_q   <= re_x * re_x;
        sq_im_q   <= im_x * im_x;
        if (s2_v_q && !rst) mem[{~pub_bank_q, s2_meta_q.idx}] <= mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            cnt_q        <= '0;
            taint_q      <= 1'b0;
            ready_q      <= 1'b0;
            s0_v_q       <= 1'b0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            pub_bank_q   <= 1'b0;
            run_bin_q    <= '0;
            run_mag_q    <= '0;
            run_exp_q    <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            frame_exp_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            taint_q      <= taint_d;
            ready_q      <= 1'b1;
            s0_v_q       <= beat_we;
            s1_v_q       <= s0_v_q;
            s2_v_q       <= s1_v_q;
            frame_done_q <= s2_v_q && s2_meta_q.done;
            frame_err_q  <= s2_v_q && s2_meta_q.err;
            if (s2_v_q) begin
                run_bin_q <= nxt_bin;
                run_mag_q <= nxt_mag;
                run_exp_q <= nxt_exp;
                if (s2_meta_q.done) begin
                    pub_bank_q  <= ~pub_bank_q;
                    peak_bin_q  <= nxt_bin;
                    peak_mag_q  <= nxt_mag;
                    frame_exp_q <= nxt_exp;
                end
            end
            rd_data_q <= mem[{pub_bank_q, rd_addr}];
        end
    end

    assign src.source_ready = ready_q;
    assign busy       = (state_q == CAPTURE);
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign frame_exp  = frame_exp_q;
endmodule

// File: tb/tb_fft_spectrum_capture.sv
// tb/tb_fft_spectrum_capture.sv - self-checking bench for fft_spectrum_capture
module tb_fft_spectrum_capture;
    localparam int N    = 512;
    localparam int DW   = 16;
    localparam int EXPW = 6;
    localparam int AW   = 9;
    localparam int PS   = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            frame_done, frame_err, busy;
    logic [AW-1:0]   peak_bin;
    logic [2*DW-1:0] peak_mag;
    logic [EXPW-1:0] frame_exp;

    always #5 clk = ~clk;

    fft_spectrum_capture_if #(.DW(DW), .EXPW(EXPW)) src ();

    fft_spectrum_capture #(.N_POINTS(N), .DW(DW), .EXPW(EXPW), .PEAK_START(PS)) dut (
        .clk(clk), .rst(rst), .src(src), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_err(frame_err), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .frame_exp(frame_exp), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) n_done++;
        if (frame_err === 1'b1)  n_err++;
    end

    // Reference model: what the published bank, peak and event counts should be.
    logic signed [DW-1:0] fre [N];
    logic signed [DW-1:0] fim [N];
    logic [2*DW-1:0]      pub_mag [N];
    logic [AW-1:0]        m_peak_bin = '0;
    logic [2*DW-1:0]      m_peak_mag = '0;
    logic [EXPW-1:0]      m_exp = '0;
    logic                 m_bank = 1'b0;
    int                   m_done = 0;
    int                   m_err  = 0;
    bit                   m_open = 1'b0;

    function automatic logic [2*DW-1:0] sqmag(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        longint a, b;
        a = r;
        b = i;
        return 32'(a * a + b * b);
    endfunction

    task automatic model_reset();
        m_peak_bin = '0;
        m_peak_mag = '0;
        m_exp      = '0;
        m_bank     = 1'b0;
        m_open     = 1'b0;
    endtask

    task automatic model_frame(input int len, input bit eop_last, input int err_bin, input logic [EXPW-1:0] e);
        logic [2*DW-1:0] best;
        if (m_open) m_err++;
        m_open = 1'b0;
        if (len == N && eop_last && !(err_bin >= 0 && err_bin < len)) begin
            for (int i = 0; i < N; i++) pub_mag[i] = sqmag(fre[i], fim[i]);
            best = '0;
            for (int i = PS; i < N; i++) if (pub_mag[i] > best) best = pub_mag[i];
            m_peak_mag = best;
            m_peak_bin = AW'(PS);
            for (int i = N - 1; i >= PS; i--) if (pub_mag[i] == best) m_peak_bin = AW'(i);
            m_exp  = e;
            m_bank = ~m_bank;
            m_done++;
        end else if (len == N || eop_last) begin
            m_err++;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic idle_src();
        src.source_valid = 1'b0;
        src.source_sop   = 1'b0;
        src.source_eop   = 1'b0;
        src.source_real  = '0;
        src.source_imag  = '0;
        src.source_exp   = '0;
        src.source_error = 2'b00;
    endtask

    task automatic send_frame(input int len, input bit eop_last, input int err_bin, input logic [EXPW-1:0] e);
        for (int i = 0; i < len; i++) begin
            src.source_valid = 1'b1;
            src.source_sop   = (i == 0);
            src.source_eop   = eop_last && (i == len - 1);
            src.source_real  = fre[i];
            src.source_imag  = fim[i];
            src.source_exp   = (i == 0) ? e : EXPW'($urandom);
            src.source_error = (i == err_bin) ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
        end
        idle_src();
        model_frame(len, eop_last, err_bin, e);
    endtask

    task automatic fill_random(input int span);
        int t;
        for (int i = 0; i < N; i++) begin
            t = $urandom_range(0, 2 * span);
            fre[i] = DW'(t - span);
            t = $urandom_range(0, 2 * span);
            fim[i] = DW'(t - span);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic read_bin(input logic [AW-1:0] a, output logic [2*DW-1:0] v);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic test_reset();
        idle_src();
        rd_addr = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({src.source_ready, frame_done, frame_err, busy, peak_bin, peak_mag, frame_exp, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b done=%b err=%b busy=%b pb=%0d pm=%0d exp=%0d rd=%0d want all 0",
                     src.source_ready, frame_done, frame_err, busy, peak_bin, peak_mag, frame_exp, rd_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (src.source_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got=%b want=1", src.source_ready);
        end
    endtask

    task automatic test_ramp();
        logic [4:0]      pat;
        logic [2*DW-1:0] rdv, v;
        logic [AW-1:0]   a;
        for (int k = 0; k < N; k++) begin
            fre[k] = DW'(k);
            fim[k] = '0;
        end
        rd_addr = AW'(10);
        send_frame(N, 1'b1, -1, 6'h3D);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pat[c] = frame_done;
            if (c == 4) rdv = rd_data;
        end
        checks++;
        if (pat !== 5'b01000) begin
            errors++;
            $display("FAIL ramp_done_timing got=%b want=01000", pat);
        end
        checks++;
        if (rdv !== 32'd100) begin
            errors++;
            $display("FAIL ramp_read_in_done_cycle got=%0d want=100", rdv);
        end
        settle();
        checks++;
        if (n_done !== m_done || n_err !== m_err) begin
            errors++;
            $display("FAIL ramp_events got done=%0d err=%0d want done=%0d err=%0d", n_done, n_err, m_done, m_err);
        end
        checks++;
        if (peak_bin !== 9'd511 || peak_mag !== 32'd261121 || frame_exp !== 6'h3D || peak_mag !== m_peak_mag) begin
            errors++;
            $display("FAIL ramp_peak got bin=%0d mag=%0d exp=%h want 511 261121 3d", peak_bin, peak_mag, frame_exp);
        end
        checks++;
        if (dut.pub_bank_q !== m_bank) begin
            errors++;
            $display("FAIL ramp_bank got=%b want=%b", dut.pub_bank_q, m_bank);
        end
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? AW'(10) : AW'($urandom_range(0, N - 1));
            read_bin(a, v);
            checks++;
            if (v !== pub_mag[a]) begin
                errors++;
                $display("FAIL ramp_read[%0d] got=%0d want=%0d", a, v, pub_mag[a]);
            end
        end
    endtask

    task automatic test_dc_peak();
        logic [2*DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            fre[i] = '0;
            fim[i] = '0;
        end
        fre[0]  = 16'sd32767;
        fre[37] = -16'sd32768;
        fim[37] = -16'sd32768;
        send_frame(N, 1'b1, -1, 6'h05);
        settle();
        checks++;
        if (peak_bin !== 9'd37 || peak_mag !== 32'h8000_0000 || peak_bin !== m_peak_bin || frame_exp !== m_exp) begin
            errors++;
            $display("FAIL dc_peak got bin=%0d mag=%h exp=%h want 37 80000000 %h", peak_bin, peak_mag, frame_exp, m_exp);
        end
        read_bin(AW'(0), v);
        checks++;
        if (v !== pub_mag[0]) begin
            errors++;
            $display("FAIL dc_read0 got=%0d want=%0d", v, pub_mag[0]);
        end
        checks++;
        if (n_done !== m_done || n_err !== m_err) begin
            errors++;
            $display("FAIL dc_events got done=%0d err=%0d want done=%0d err=%0d", n_done, n_err, m_done, m_err);
        end
    endtask

    task automatic test_early_eop();
        logic [2*DW-1:0] v;
        logic [AW-1:0]   a;
        fill_random(30000);
        send_frame(301, 1'b1, -1, 6'h11);
        settle();
        checks++;
        if (n_done !== m_done || n_err !== m_err) begin
            errors++;
            $display("FAIL early_eop_events got done=%0d err=%0d want done=%0d err=%0d", n_done, n_err, m_done, m_err);
        end
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom_range(0, 300));
            read_bin(a, v);
            checks++;
            if (v !== pub_mag[a]) begin
                errors++;
                $display("FAIL early_eop_hold[%0d] got=%0d want=%0d", a, v, pub_mag[a]);
            end
        end
        fill_random(32767);
        send_frame(N, 1'b1, -1, 6'h22);
        settle();
        checks++;
        if (n_done !== m_done || peak_bin !== m_peak_bin || peak_mag !== m_peak_mag || frame_exp !== m_exp) begin
            errors++;
            $display("FAIL early_eop_recover got done=%0d bin=%0d mag=%0d exp=%h want %0d %0d %0d %h",
                     n_done, peak_bin, peak_mag, frame_exp, m_done, m_peak_bin, m_peak_mag, m_exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] v;
        logic [AW-1:0]   a;
        int              d0, e0;
        d0 = n_done;
        e0 = n_err;
        fill_random(32767);
        send_frame(N, 1'b1, -1, 6'h01);
        fill_random(20000);
        send_frame(N, 1'b1, -1, 6'h3F);
        fill_random(32767);
        send_frame(N, 1'b1, 5, 6'h10);
        settle();
        checks++;
        if (n_done - d0 !== 2 || n_err - e0 !== 1 || n_done !== m_done || n_err !== m_err) begin
            errors++;
            $display("FAIL b2b_events got done+%0d err+%0d want done+2 err+1", n_done - d0, n_err - e0);
        end
        checks++;
        if (peak_bin !== m_peak_bin || peak_mag !== m_peak_mag || frame_exp !== 6'h3F || dut.pub_bank_q !== m_bank) begin
            errors++;
            $display("FAIL b2b_hold got bin=%0d mag=%0d exp=%h bank=%b want %0d %0d 3f %b",
                     peak_bin, peak_mag, frame_exp, dut.pub_bank_q, m_peak_bin, m_peak_mag, m_bank);
        end
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom_range(0, N - 1));
            read_bin(a, v);
            checks++;
            if (v !== pub_mag[a]) begin
                errors++;
                $display("FAIL b2b_read[%0d] got=%0d want=%0d", a, v, pub_mag[a]);
            end
        end
    endtask

    task automatic test_midframe_sop();
        fill_random(1000);
        send_frame(100, 1'b0, -1, 6'h07);
        fill_random(1000);
        send_frame(N, 1'b1, -1, 6'h08);
        settle();
        checks++;
        if (n_done !== m_done || n_err !== m_err || peak_bin !== m_peak_bin || peak_mag !== m_peak_mag || frame_exp !== m_exp) begin
            errors++;
            $display("FAIL mid_sop got done=%0d err=%0d bin=%0d mag=%0d exp=%h want %0d %0d %0d %0d %h",
                     n_done, n_err, peak_bin, peak_mag, frame_exp, m_done, m_err, m_peak_bin, m_peak_mag, m_exp);
        end
    endtask

    task automatic test_ties();
        fill_random(100);
        fre[20] = 16'sd1000;
        fim[20] = -16'sd1000;
        fre[40] = -16'sd1000;
        fim[40] = 16'sd1000;
        send_frame(N, 1'b1, -1, 6'h2A);
        settle();
        checks++;
        if (peak_bin !== 9'd20 || peak_bin !== m_peak_bin || peak_mag !== m_peak_mag) begin
            errors++;
            $display("FAIL ties got bin=%0d mag=%0d want 20 %0d", peak_bin, peak_mag, m_peak_mag);
        end
    endtask

    task automatic test_random();
        logic [2*DW-1:0] v;
        logic [AW-1:0]   a;
        int              kind, len;
        for (int f = 0; f < 6; f++) begin
            kind = $urandom_range(0, 4);
            fill_random((f % 2 == 0) ? 32767 : 3);
            len = $urandom_range(1, N - 1);
            case (kind)
                0: send_frame(N, 1'b1, -1, EXPW'($urandom));
                1: send_frame(len, 1'b1, -1, EXPW'($urandom));
                2: send_frame(N, 1'b0, -1, EXPW'($urandom));
                3: send_frame(N, 1'b1, $urandom_range(0, N - 1), EXPW'($urandom));
                default: send_frame(len, 1'b0, -1, EXPW'($urandom));
            endcase
        end
        fill_random(32767);
        send_frame(N, 1'b1, -1, EXPW'($urandom));
        settle();
        checks++;
        if (n_done !== m_done || n_err !== m_err || peak_bin !== m_peak_bin || peak_mag !== m_peak_mag
            || frame_exp !== m_exp || dut.pub_bank_q !== m_bank) begin
            errors++;
            $display("FAIL random_frames got done=%0d err=%0d bin=%0d mag=%0d want %0d %0d %0d %0d",
                     n_done, n_err, peak_bin, peak_mag, m_done, m_err, m_peak_bin, m_peak_mag);
        end
        for (int k = 0; k < 8; k++) begin
            a = AW'($urandom_range(0, N - 1));
            read_bin(a, v);
            checks++;
            if (v !== pub_mag[a]) begin
                errors++;
                $display("FAIL random_read[%0d] got=%0d want=%0d", a, v, pub_mag[a]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int d0;
        fill_random(32767);
        send_frame(200, 1'b0, -1, 6'h15);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy got=%b want=1", busy);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({src.source_ready, frame_done, frame_err, busy, peak_bin, peak_mag, frame_exp, rd_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b busy=%b pb=%0d pm=%0d exp=%0d rd=%0d want all 0",
                     src.source_ready, busy, peak_bin, peak_mag, frame_exp, rd_data);
        end
        model_reset();
        d0 = n_done;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_random(32767);
        send_frame(N, 1'b1, -1, 6'h2C);
        settle();
        checks++;
        if (n_done - d0 !== 1 || n_err !== m_err || dut.pub_bank_q !== 1'b1 || m_bank !== 1'b1
            || peak_bin !== m_peak_bin || peak_mag !== m_peak_mag || frame_exp !== 6'h2C) begin
            errors++;
            $display("FAIL midreset_recover got done+%0d err=%0d bank=%b bin=%0d want done+1 err=%0d bank=1 bin=%0d",
                     n_done - d0, n_err, dut.pub_bank_q, peak_bin, m_err, m_peak_bin);
        end
    endtask

    initial begin
        idle_src();
        rd_addr = '0;
        test_reset();
        test_ramp();
        test_dc_peak();
        test_early_eop();
        test_back_to_back();
        test_midframe_sop();
        test_ties();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
